// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Round-robin arbiter that shares one 4:1 data mux among four requesters
//   and streams the granted lane to a single valid/ready consumer. Each grant
//   is limited to MAX_BURST transferred beats. After every release there is
//   one IDLE cycle before the next grant is issued.
//
//   Build option: define ARB_FIXED_PRIO_EN for fixed priority (req[0]
//   highest). The rotating pointer is then removed.
//
//   Ports
//     clk        system clock, rising edge
//     rst_n      asynchronous active-low reset
//     req        per-requester beat-available flags
//     in_data    four lanes, lane i at [i*DATA_W +: DATA_W]
//     out_ready  consumer accepts a beat this cycle
//     gnt        registered one-hot grant, zero when idle
//     sel        registered binary index of the granted lane
//     out_valid  beat present on out_data
//     out_data   lane selected by sel (combinational)
//     busy       high while a grant is active
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no grant; arbitrate among req and grant on the next edge
//   GRANT | lane sel owns the mux until burst exhausted or req withdrawn
module mux4_rr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [4*DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic [3:0]        gnt,
  output logic [1:0]        sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  state_t     state, state_nx;
  logic [3:0] gnt_nx;
  logic [1:0] sel_nx;
  logic [7:0] cnt, cnt_nx;
  logic [1:0] base;
  logic       pick_vld;
  logic [1:0] pick_idx;

`ifdef ARB_FIXED_PRIO_EN
  assign base = 2'd0;
`else
  logic [1:0] ptr, ptr_nx;
  assign base = ptr;
`endif

  assign busy      = (state == GRANT);
  assign out_valid = (state == GRANT) && req[sel];
  assign out_data  = in_data[sel*DATA_W +: DATA_W];

  // Scan from base upward (mod 4). Iterating from the far end down lets the
  // closest set request overwrite the others, so the nearest one wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[2'(base + 2'(k))]) begin
        pick_vld = 1'b1;
        pick_idx = 2'(base + 2'(k));
      end
    end
  end

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    sel_nx   = sel;
    cnt_nx   = cnt;
`ifndef ARB_FIXED_PRIO_EN
    ptr_nx   = ptr;
`endif
    unique case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nx = GRANT;
          gnt_nx   = 4'b0001 << pick_idx;
          sel_nx   = pick_idx;
          cnt_nx   = 8'd0;
        end
      end
      GRANT: begin
        // A withdrawn request releases without a beat. Otherwise a transfer
        // on the last allowed beat releases. sel is kept so out_data keeps
        // showing the last lane while idle.
        if (!req[sel] || (out_ready && cnt == LAST_BEAT)) begin
          state_nx = IDLE;
          gnt_nx   = 4'b0000;
`ifndef ARB_FIXED_PRIO_EN
          ptr_nx   = sel + 2'd1;
`endif
        end else if (out_ready) begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      sel   <= 2'd0;
      cnt   <= 8'd0;
`ifndef ARB_FIXED_PRIO_EN
      ptr   <= 2'd0;
`endif
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      sel   <= sel_nx;
      cnt   <= cnt_nx;
`ifndef ARB_FIXED_PRIO_EN
      ptr   <= ptr_nx;
`endif
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter (DATA_W=8, MAX_BURST=4).
// Expected beats are queued by the stimulus; a negedge monitor pops and
// compares each transferred beat. Grant/bubble timing is checked inline.
module tb_mux4_rr_arbiter;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [3:0]        req = 4'b0000;
  logic [4*DATA_W-1:0] in_data;
  logic              out_ready = 1'b1;
  logic [3:0]        gnt;
  logic [1:0]        sel;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              busy;

  logic [DATA_W-1:0] lane_val [4] = '{8'h3C, 8'hA5, 8'h5A, 8'hC3};
  logic [DATA_W+1:0] exp_q [$];
  logic [DATA_W+1:0] e;
  int n_cmp = 0;
  int n_err = 0;
  int order [5];

  assign in_data = {lane_val[3], lane_val[2], lane_val[1], lane_val[0]};

  mux4_rr_arbiter #(.DATA_W(DATA_W), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .in_data(in_data),
    .out_ready(out_ready), .gnt(gnt), .sel(sel), .out_valid(out_valid),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int lane, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({2'(lane), lane_val[lane]});
  endtask

  task automatic apply_reset();
    req = 4'b0000;
    out_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: sel=%0d data=%0h expected no beat", sel, out_data);
      end else begin
        e = exp_q.pop_front();
        check("beat_sel", 32'(sel), 32'(e[DATA_W+1:DATA_W]));
        check("beat_data", 32'(out_data), 32'(e[DATA_W-1:0]));
        check("beat_gnt", 32'(gnt), 32'(4'b0001 << e[DATA_W+1:DATA_W]));
      end
    end
  end

  initial begin
    // reset asserted with all requests pending: outputs clear without an edge
    req = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_sel", 32'(sel), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    apply_reset();

    // single requester: two bursts of lane 2 with a bubble between
    req = 4'b0100;
    push(2, 8);
    for (int b = 0; b < 2; b++) begin
      tick();
      check("single_gnt", 32'(gnt), 32'h4);
      check("single_sel", 32'(sel), 2);
      repeat (4) tick();
      check("single_bubble_busy", 32'(busy), 0);
      check("single_bubble_gnt", 32'(gnt), 0);
    end
    req = 4'b0000;
    tick();

    // fairness: all requesting
    apply_reset();
`ifdef ARB_FIXED_PRIO_EN
    order = '{0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    for (int b = 0; b < 5; b++) push(order[b], 4);
    req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      tick();
      check("fair_gnt", 32'(gnt), 32'(4'b0001 << order[b]));
      repeat (4) tick();
      check("fair_bubble_busy", 32'(busy), 0);
    end
    req = 4'b0000;
    tick();

    // backpressure during requester 1's burst
    apply_reset();
    push(1, 4);
    req = 4'b0010;
    tick();
    check("bp_gnt", 32'(gnt), 32'h2);
    repeat (2) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_gnt", 32'(gnt), 32'h2);
      check("bp_hold_data", 32'(out_data), 32'(lane_val[1]));
      check("bp_hold_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    tick();
    check("bp_not_released", 32'(busy), 1);
    tick();
    check("bp_released", 32'(busy), 0);
    req = 4'b0000;
    tick();

    // withdrawal: requester 1 drops after 2 beats, requester 3 waiting
    apply_reset();
    push(1, 2);
    push(3, 4);
    req = 4'b1010;
    tick();
    check("wd_gnt1", 32'(gnt), 32'h2);
    repeat (2) tick();
    req = 4'b1000;
    #1;
    check("wd_valid_drop", 32'(out_valid), 0);
    tick();
    check("wd_release_busy", 32'(busy), 0);
    tick();
    check("wd_gnt3", 32'(gnt), 32'h8);
    check("wd_sel3", 32'(sel), 3);
    repeat (4) tick();
    check("wd_done_busy", 32'(busy), 0);
    req = 4'b0000;
    tick();

    // async reset during beat 3 of requester 2
    apply_reset();
    push(2, 2);
    push(0, 4);
    req = 4'b0100;
    tick();
    check("ar_gnt2", 32'(gnt), 32'h4);
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    check("ar_gnt_cleared", 32'(gnt), 0);
    check("ar_busy_cleared", 32'(busy), 0);
    check("ar_valid_cleared", 32'(out_valid), 0);
    check("ar_sel_cleared", 32'(sel), 0);
    #2;
    req = 4'b0101;
    rst_n = 1'b1;
    tick();
    check("ar_gnt0", 32'(gnt), 32'h1);
    repeat (4) tick();
    check("ar_done_busy", 32'(busy), 0);
    req = 4'b0000;
    repeat (2) tick();

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
